// File: rtl/hazard_fwd_ctrl_pkg.sv
// Purpose : shared types for the 5-stage hazard/forwarding controller.
// Contents: opcode class enum, E-stage bypass select enum, controller state enum,
//           counter width and the per-operand bypass priority helper.
package hazard_fwd_ctrl_pkg;

  typedef enum logic [2:0] {
    R_type      = 3'd0,
    I_type_alu  = 3'd1,
    I_type_load = 3'd2,
    S_type      = 3'd3,
    B_type      = 3'd4,
    J_type      = 3'd5,
    U_type      = 3'd6
  } type_opcode_e;

  typedef enum logic [1:0] {
    FWD_RF = 2'd0,
    FWD_M  = 2'd1,
    FWD_W  = 2'd2
  } fwd_sel_e;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LD_STALL = 2'd1,
    MC_WAIT  = 2'd2,
    FLUSH    = 2'd3
  } hz_state_e;

  // Wide enough for LOAD_LAT-1 (<=3) and FLUSH_DEPTH-2 extra flush cycles.
  localparam int CNT_W = 4;

  // M holds the younger result, so it wins over W when both match.
  function automatic fwd_sel_e fwd_pick(input logic used, input logic hit_m, input logic hit_w);
    fwd_sel_e sel;
    sel = FWD_RF;
    if (used) begin
      if (hit_m)      sel = FWD_M;
      else if (hit_w) sel = FWD_W;
    end
    return sel;
  endfunction

endpackage

// File: rtl/hazard_fwd_ctrl_scoreboard.sv
// Purpose : pending-write scoreboard for the single multi-cycle (mul/div) unit.
// Latency : hit is combinational and already reflects this cycle's done/start.
// Stall   : start_blocked flags an issue attempt while the unit is still occupied.
// Ports   : mc_start/mc_rd/mc_done from the pipeline, rd_addr = N_SRC D-stage
//           source addresses, hit = per-source pending flag, busy = unit occupied.
module hz_scoreboard
  import hazard_fwd_ctrl_pkg::*;
#(
  parameter int N_SRC = 2,
  parameter int RA_W  = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    mc_start,
  input  logic [RA_W-1:0]         mc_rd,
  input  logic                    mc_done,
  input  logic [N_SRC*RA_W-1:0]   rd_addr,
  output logic [N_SRC-1:0]        hit,
  output logic                    start_blocked,
  output logic                    busy
);

  localparam int DEPTH = 2 ** RA_W;

  logic [DEPTH-1:0] bits_q;
  logic [DEPTH-1:0] bits_nxt;
  logic [RA_W-1:0]  pend_q;
  logic             busy_q;
  logic             accept;
  logic             clr;

  // Only one op can be in flight, so the completing op is always pend_q.
  assign clr           = mc_done & busy_q;
  assign accept        = mc_start & (~busy_q | mc_done);
  assign start_blocked = mc_start & busy_q & ~mc_done;

  // Clear before set so back-to-back ops on the same rd keep the bit.
  always_comb begin
    bits_nxt = bits_q;
    if (clr) bits_nxt[pend_q] = 1'b0;
    if (accept && (mc_rd != '0)) bits_nxt[mc_rd] = 1'b1;
  end

  // Reading the next-state view gives same-cycle release on done and
  // catches a reader of an op issuing this very cycle.
  always_comb begin
    hit = '0;
    for (int i = 0; i < N_SRC; i++) begin
      hit[i] = bits_nxt[rd_addr[i*RA_W +: RA_W]];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bits_q <= '0;
      pend_q <= '0;
      busy_q <= 1'b0;
    end else begin
      bits_q <= bits_nxt;
      if (accept) pend_q <= mc_rd;
      busy_q <= accept | (busy_q & ~mc_done);
    end
  end

  assign busy = busy_q;

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Purpose : hazard and forwarding control for the F/D/E/M/W core: E bypass
//           selects, load-use bubbles, multi-cycle scoreboard stalls, branch flush.
// Latency : all outputs combinational from inputs plus registered counters/state.
// Stall   : stall_F/stall_D hold the front end while flush_E injects a bubble;
//           a taken branch overrides any stall. All outputs are 0 while rst is high.
// Ports   : rs_*/rs_valid_* per-source addresses, rd_*/reg_wr_* per-stage writes,
//           mc_* multi-cycle handshake, br_taken, fwd_sel (2 bits per operand).
module hazard_fwd_ctrl
  import hazard_fwd_ctrl_pkg::*;
#(
  parameter int N_SRC       = 2,
  parameter int RA_W        = 5,
  parameter int LOAD_LAT    = 1,
  parameter int FLUSH_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_SRC*RA_W-1:0] rs_D,
  input  logic [N_SRC-1:0]      rs_valid_D,
  input  logic [N_SRC*RA_W-1:0] rs_E,
  input  logic [N_SRC-1:0]      rs_valid_E,
  input  logic [RA_W-1:0]       rd_E,
  input  logic                  reg_wr_E,
  input  type_opcode_e          opcode_E,
  input  logic [RA_W-1:0]       rd_M,
  input  logic [RA_W-1:0]       rd_W,
  input  logic                  reg_wr_M,
  input  logic                  reg_wr_W,
  input  logic                  mc_start,
  input  logic [RA_W-1:0]       mc_rd,
  input  logic                  mc_done,
  input  logic                  br_taken,
  output logic [N_SRC*2-1:0]    fwd_sel,
  output logic                  stall_F,
  output logic                  stall_D,
  output logic                  flush_D,
  output logic                  flush_E,
  output logic                  mc_busy
);

  // The first bubble comes from the detect cycle; the counter covers the rest.
  localparam logic [CNT_W-1:0] LD_RELOAD  = CNT_W'(LOAD_LAT - 1);
  localparam logic [CNT_W-1:0] FL_RELOAD  = (FLUSH_DEPTH > 2) ? CNT_W'(FLUSH_DEPTH - 2) : '0;
  localparam logic             FLUSH_E_ON = (FLUSH_DEPTH >= 2);

  hz_state_e        state_q, state_nxt;
  logic [CNT_W-1:0] ld_cnt_q, ld_cnt_nxt;
  logic [CNT_W-1:0] fl_cnt_q, fl_cnt_nxt;

  logic             ld_hit;
  logic             mc_hold;
  logic             flushing;
  logic             hold;
  logic [N_SRC-1:0] sb_hit;
  logic             start_blocked;
  logic             sb_busy;

  hz_scoreboard #(
    .N_SRC (N_SRC),
    .RA_W  (RA_W)
  ) u_sb (
    .clk           (clk),
    .rst           (rst),
    .mc_start      (mc_start),
    .mc_rd         (mc_rd),
    .mc_done       (mc_done),
    .rd_addr       (rs_D),
    .hit           (sb_hit),
    .start_blocked (start_blocked),
    .busy          (sb_busy)
  );

  always_comb begin
    ld_hit = 1'b0;
    if ((opcode_E == I_type_load) && reg_wr_E && (rd_E != '0)) begin
      for (int i = 0; i < N_SRC; i++) begin
        if (rs_valid_D[i] && (rs_D[i*RA_W +: RA_W] == rd_E)) ld_hit = 1'b1;
      end
    end
  end

  assign mc_hold  = start_blocked | (|(sb_hit & rs_valid_D));
  assign flushing = br_taken | (state_q == FLUSH);
  // Load and multi-cycle holds are independent; the front end waits for both.
  assign hold     = ~flushing & (ld_hit | (ld_cnt_q != '0) | mc_hold);

  always_comb begin
    fl_cnt_nxt = '0;
    if (br_taken)              fl_cnt_nxt = FL_RELOAD;
    else if (fl_cnt_q != '0)   fl_cnt_nxt = fl_cnt_q - CNT_W'(1);

    // A flush kills the waiting consumer, so any pending load bubble is dropped.
    ld_cnt_nxt = '0;
    if (flushing)              ld_cnt_nxt = '0;
    else if (ld_hit)           ld_cnt_nxt = LD_RELOAD;
    else if (ld_cnt_q != '0)   ld_cnt_nxt = ld_cnt_q - CNT_W'(1);

    state_nxt = RUN;
    if (fl_cnt_nxt != '0)            state_nxt = FLUSH;
    else if (!flushing && mc_hold)   state_nxt = MC_WAIT;
    else if (ld_cnt_nxt != '0)       state_nxt = LD_STALL;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RUN;
      ld_cnt_q <= '0;
      fl_cnt_q <= '0;
    end else begin
      state_q  <= state_nxt;
      ld_cnt_q <= ld_cnt_nxt;
      fl_cnt_q <= fl_cnt_nxt;
    end
  end

  always_comb begin
    fwd_sel = '0;
    stall_F = 1'b0;
    stall_D = 1'b0;
    flush_D = 1'b0;
    flush_E = 1'b0;
    mc_busy = 1'b0;
    if (!rst) begin
      for (int i = 0; i < N_SRC; i++) begin
        fwd_sel[2*i +: 2] = fwd_pick(
          rs_valid_E[i] && (rs_E[i*RA_W +: RA_W] != '0),
          reg_wr_M && (rd_M == rs_E[i*RA_W +: RA_W]),
          reg_wr_W && (rd_W == rs_E[i*RA_W +: RA_W]));
      end
      stall_F = hold;
      stall_D = hold;
      flush_D = flushing;
      flush_E = flushing ? FLUSH_E_ON : hold;
      mc_busy = sb_busy;
    end
  end

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
module tb_hazard_fwd_ctrl;
  import hazard_fwd_ctrl_pkg::*;

  localparam int NS = 2;
  localparam int RA = 5;
  localparam int LL = 2;
  localparam int FD = 3;

  logic clk = 1'b0;
  logic rst;
  logic [NS*RA-1:0] rs_D, rs_E;
  logic [NS-1:0]    rs_valid_D, rs_valid_E;
  logic [RA-1:0]    rd_E, rd_M, rd_W, mc_rd;
  logic             reg_wr_E, reg_wr_M, reg_wr_W, mc_start, mc_done, br_taken;
  type_opcode_e     opcode_E;
  logic [NS*2-1:0]  fwd_sel;
  logic             stall_F, stall_D, flush_D, flush_E, mc_busy;

  always #5 clk = ~clk;

  hazard_fwd_ctrl #(.N_SRC(NS), .RA_W(RA), .LOAD_LAT(LL), .FLUSH_DEPTH(FD)) dut (
    .clk(clk), .rst(rst),
    .rs_D(rs_D), .rs_valid_D(rs_valid_D), .rs_E(rs_E), .rs_valid_E(rs_valid_E),
    .rd_E(rd_E), .reg_wr_E(reg_wr_E), .opcode_E(opcode_E),
    .rd_M(rd_M), .rd_W(rd_W), .reg_wr_M(reg_wr_M), .reg_wr_W(reg_wr_W),
    .mc_start(mc_start), .mc_rd(mc_rd), .mc_done(mc_done), .br_taken(br_taken),
    .fwd_sel(fwd_sel), .stall_F(stall_F), .stall_D(stall_D),
    .flush_D(flush_D), .flush_E(flush_E), .mc_busy(mc_busy)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: remaining-bubble counts, outstanding multi-cycle dest set.
  int       m_ld, m_fl, m_pend, n_ld, n_fl, n_pend;
  bit       m_busy, n_busy;
  bit [31:0] m_sb, n_sb;
  logic [3:0] e_fwd;
  bit       e_stall, e_fD, e_fE, e_busy;
  bit       chk_en = 1'b0;

  task automatic model_eval();
    bit ldh, acc, rej, mch, fl, hold;
    bit [31:0] view;
    logic [RA-1:0] a;
    e_fwd = '0; e_stall = 0; e_fD = 0; e_fE = 0; e_busy = 0;
    if (rst) begin
      n_ld = 0; n_fl = 0; n_pend = 0; n_busy = 0; n_sb = '0;
    end else begin
      for (int i = 0; i < NS; i++) begin
        a = rs_E[i*RA +: RA];
        if (rs_valid_E[i] && a != 0) begin
          if (reg_wr_M && rd_M == a)      e_fwd[2*i +: 2] = 2'd1;
          else if (reg_wr_W && rd_W == a) e_fwd[2*i +: 2] = 2'd2;
        end
      end
      ldh = 0;
      if (opcode_E == I_type_load && reg_wr_E && rd_E != 0)
        for (int i = 0; i < NS; i++)
          if (rs_valid_D[i] && rs_D[i*RA +: RA] == rd_E) ldh = 1;
      acc = mc_start && (!m_busy || mc_done);
      rej = mc_start && m_busy && !mc_done;
      view = m_sb;
      if (mc_done && m_busy) view[m_pend] = 1'b0;
      if (acc && mc_rd != 0) view[mc_rd] = 1'b1;
      mch = rej;
      for (int i = 0; i < NS; i++)
        if (rs_valid_D[i] && view[rs_D[i*RA +: RA]]) mch = 1;
      fl = br_taken || (m_fl > 0);
      hold = !fl && (ldh || m_ld > 0 || mch);
      e_stall = hold; e_fD = fl; e_fE = fl ? (FD >= 2) : hold; e_busy = m_busy;
      n_sb = view;
      n_busy = acc ? 1'b1 : (mc_done ? 1'b0 : m_busy);
      n_pend = acc ? int'(mc_rd) : m_pend;
      n_fl = br_taken ? ((FD > 2) ? FD - 2 : 0) : ((m_fl > 0) ? m_fl - 1 : 0);
      n_ld = fl ? 0 : (ldh ? LL - 1 : ((m_ld > 0) ? m_ld - 1 : 0));
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("fwd_sel", fwd_sel, e_fwd);
      check("stall_F", stall_F, e_stall);
      check("stall_D", stall_D, e_stall);
      check("flush_D", flush_D, e_fD);
      check("flush_E", flush_E, e_fE);
      check("mc_busy", mc_busy, e_busy);
    end
  end

  task automatic step();
    model_eval();
    chk_en = 1'b1;
    @(negedge clk);
    #1;
  endtask

  task automatic adv();
    m_ld = n_ld; m_fl = n_fl; m_pend = n_pend; m_busy = n_busy; m_sb = n_sb;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 0; rs_D = '0; rs_valid_D = '0; rs_E = '0; rs_valid_E = '0;
    rd_E = '0; reg_wr_E = 0; opcode_E = R_type; rd_M = '0; rd_W = '0;
    reg_wr_M = 0; reg_wr_W = 0; mc_start = 0; mc_rd = '0; mc_done = 0; br_taken = 0;
  endtask

  task automatic load_use_x7();
    idle();
    opcode_E = I_type_load; reg_wr_E = 1; rd_E = 5'd7;
    rs_D = {5'd7, 5'd3}; rs_valid_D = 2'b10;
  endtask

  initial begin
    m_ld = 0; m_fl = 0; m_pend = 0; m_busy = 0; m_sb = '0;
    // Reset cycle with inputs that would otherwise light every output.
    idle(); rst = 1; br_taken = 1; reg_wr_M = 1; rd_M = 5'd5; rs_E = {5'd5, 5'd5};
    rs_valid_E = 2'b11; mc_start = 1; mc_rd = 5'd3;
    step();
    check("rst_fwd", fwd_sel, 0); check("rst_flushD", flush_D, 0); check("rst_busy", mc_busy, 0);
    adv();
    idle(); rst = 1; step(); adv();

    // Forwarding: M over W, W alone, x0 never, invalid operand ignored.
    idle(); rd_M = 5'd5; reg_wr_M = 1; rd_W = 5'd5; reg_wr_W = 1;
    rs_E = {5'd6, 5'd5}; rs_valid_E = 2'b11;
    step(); check("fwd_m_prio", fwd_sel, 4'b0001); adv();
    reg_wr_M = 0;
    step(); check("fwd_w", fwd_sel, 4'b0010); adv();
    rd_M = 5'd0; reg_wr_M = 1; rd_W = 5'd0; rs_E = '0;
    step(); check("fwd_x0", fwd_sel, 4'b0000); adv();
    rd_M = 5'd5; rs_E = {5'd5, 5'd5}; rs_valid_E = 2'b10;
    step(); check("fwd_invalid", fwd_sel, 4'b0100); adv();

    // Load-use with two bubbles, then W forwarding of the loaded value.
    load_use_x7();
    step(); check("ld_c1_stall", stall_F, 1); check("ld_c1_flushE", flush_E, 1); adv();
    idle(); rs_D = {5'd7, 5'd3}; rs_valid_D = 2'b10; rd_M = 5'd7; reg_wr_M = 1;
    step(); check("ld_c2_stall", stall_D, 1); adv();
    idle(); rs_D = {5'd7, 5'd3}; rs_valid_D = 2'b10; rd_W = 5'd7; reg_wr_W = 1;
    rs_E = {5'd7, 5'd0}; rs_valid_E = 2'b10;
    step(); check("ld_c3_stall", stall_F, 0); check("ld_c3_fwd", fwd_sel, 4'b1000); adv();

    // Multi-cycle op on x9 with a reader in D.
    idle(); mc_start = 1; mc_rd = 5'd9; rs_D = {5'd0, 5'd9}; rs_valid_D = 2'b01;
    step(); check("mc_issue_stall", stall_F, 1); adv();
    mc_start = 0;
    for (int k = 0; k < 3; k++) begin
      step(); check("mc_wait_stall", stall_F, 1); check("mc_wait_busy", mc_busy, 1); adv();
    end
    mc_done = 1;
    step(); check("mc_done_release", stall_F, 0); adv();
    mc_done = 0;
    step(); check("mc_after_stall", stall_F, 0); check("mc_after_busy", mc_busy, 0); adv();

    // Taken branch while a load bubble is pending.
    load_use_x7(); step(); adv();
    idle(); rs_D = {5'd7, 5'd3}; rs_valid_D = 2'b10; br_taken = 1;
    step(); check("br_flushD", flush_D, 1); check("br_flushE", flush_E, 1); check("br_stallF", stall_F, 0); adv();
    br_taken = 0;
    step(); check("br_flushD_2nd", flush_D, 1); check("br_stall_2nd", stall_F, 0); adv();
    step(); check("br_flushD_end", flush_D, 0); check("br_ld_aborted", stall_F, 0); adv();

    // Reset in the middle of a load bubble with a multi-cycle op in flight.
    load_use_x7(); rs_D = {5'd7, 5'd4}; mc_start = 1; mc_rd = 5'd4; step(); adv();
    idle(); rst = 1;
    step(); check("rstmid_stall", stall_F, 0); check("rstmid_flushE", flush_E, 0); adv();
    idle(); rs_D = {5'd7, 5'd4}; rs_valid_D = 2'b11;
    step(); check("postrst_stall", stall_F, 0); check("postrst_busy", mc_busy, 0); adv();

    // Randomized traffic over a small register window to force collisions.
    for (int c = 0; c < 3000; c++) begin
      rst        = ($urandom_range(0, 199) == 0);
      rs_D       = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      rs_E       = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      rs_valid_D = 2'($urandom_range(0, 3));
      rs_valid_E = 2'($urandom_range(0, 3));
      rd_E       = 5'($urandom_range(0, 7));
      rd_M       = 5'($urandom_range(0, 7));
      rd_W       = 5'($urandom_range(0, 7));
      reg_wr_E   = 1'($urandom_range(0, 1));
      reg_wr_M   = 1'($urandom_range(0, 1));
      reg_wr_W   = 1'($urandom_range(0, 1));
      opcode_E   = ($urandom_range(0, 2) == 0) ? I_type_load : R_type;
      mc_start   = ($urandom_range(0, 7) == 0);
      mc_rd      = 5'($urandom_range(0, 7));
      mc_done    = ($urandom_range(0, 5) == 0);
      br_taken   = ($urandom_range(0, 19) == 0);
      step();
      adv();
    end

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
